mem_req_arbiter: RTL and testbench

//  Two-requester round-robin arbiter for the single-outstanding cs/we memory request bus that feeds the AXI/AXI-lite master.

---
 rtl/mem_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter for a single-outstanding cs/we memory bus.
// The winner's request is registered onto the downstream bus and held until
// its response arrives. The response is routed back to the owner in the same
// cycle. A hung downstream is recovered by answering the owner with an error
// and then draining the late response.
module mem_req_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  m0_cs_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_rvalid_o,
  output logic                  m0_err_o,

  input  logic                  m1_cs_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_rvalid_o,
  output logic                  m1_err_o,

  output logic                  cs_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rvalid_i,

  output logic [1:0]            grant_o
);

  localparam bit          TimeoutEn = (TIMEOUT != 0);
  // Keep at least one counter bit so the disabled configuration still elaborates.
  localparam int unsigned CntW      = TimeoutEn ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT - 1) : '0;
  localparam logic [DATA_WIDTH-1:0] ErrData = DATA_WIDTH'(ERR_DATA);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e                  state_q, state_d;
  logic                    cs_q, cs_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              grant_q, grant_d;
  logic                    last_q, last_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic                    win1;
  logic                    timeout_hit;
  logic                    done;
  logic [DATA_WIDTH-1:0]   resp_data;

  // m1 wins when it is the only requester, or on a tie when m0 went last.
  assign win1 = m1_cs_i & (~m0_cs_i | ~last_q);

  // A response on the timeout cycle takes priority over the timeout itself.
  assign timeout_hit = TimeoutEn && (state_q == StBusy) && (cnt_q == CntLast) && !rvalid_i;

  // State and request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitration, hold while busy, timeout and drain.
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cs_i || m1_cs_i) begin
          cs_d    = 1'b1;
          we_d    = win1 ? m1_we_i    : m0_we_i;
          addr_d  = win1 ? m1_addr_i  : m0_addr_i;
          wdata_d = win1 ? m1_wdata_i : m0_wdata_i;
          grant_d = win1 ? 2'b10 : 2'b01;
          last_d  = win1;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (rvalid_i) begin
          cs_d    = 1'b0;
          grant_d = 2'b00;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (timeout_hit) begin
          // cs stays high so the downstream can still finish its transfer.
          grant_d = 2'b00;
          cnt_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (rvalid_i) begin
          cs_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Response routing back to the owner; responses outside BUSY are dropped.
  always_comb begin
    done        = (state_q == StBusy) && (rvalid_i || timeout_hit);
    resp_data   = timeout_hit ? ErrData : rdata_i;
    m0_rvalid_o = done & grant_q[0];
    m1_rvalid_o = done & grant_q[1];
    m0_err_o    = m0_rvalid_o & timeout_hit;
    m1_err_o    = m1_rvalid_o & timeout_hit;
    m0_rdata_o  = m0_rvalid_o ? resp_data : '0;
    m1_rdata_o  = m1_rvalid_o ? resp_data : '0;
  end

  assign cs_o    = cs_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: a vector table, hand sequences for
// timeout/drain/reset/hold corner cases, and randomized traffic checked
// against a round-robin reference model.
module tb_mem_req_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          m0_cs_i = 1'b0, m0_we_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0;
  logic [DW-1:0] m0_wdata_i = '0;
  logic [DW-1:0] m0_rdata_o;
  logic          m0_rvalid_o, m0_err_o;
  logic          m1_cs_i = 1'b0, m1_we_i = 1'b0;
  logic [AW-1:0] m1_addr_i = '0;
  logic [DW-1:0] m1_wdata_i = '0;
  logic [DW-1:0] m1_rdata_o;
  logic          m1_rvalid_o, m1_err_o;
  logic          cs_o, we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] rdata_i = '0;
  logic          rvalid_i = 1'b0;
  logic [1:0]    grant_o;

  mem_req_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO),
    .ERR_DATA  (32'hDEADBEEF)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m0_cs_i    (m0_cs_i),
    .m0_we_i    (m0_we_i),
    .m0_addr_i  (m0_addr_i),
    .m0_wdata_i (m0_wdata_i),
    .m0_rdata_o (m0_rdata_o),
    .m0_rvalid_o(m0_rvalid_o),
    .m0_err_o   (m0_err_o),
    .m1_cs_i    (m1_cs_i),
    .m1_we_i    (m1_we_i),
    .m1_addr_i  (m1_addr_i),
    .m1_wdata_i (m1_wdata_i),
    .m1_rdata_o (m1_rdata_o),
    .m1_rvalid_o(m1_rvalid_o),
    .m1_err_o   (m1_err_o),
    .cs_o       (cs_o),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .rdata_i    (rdata_i),
    .rvalid_i   (rvalid_i),
    .grant_o    (grant_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Raise a request with new fields unless that requester is already holding one.
  task automatic request(input int k, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (k == 0) begin
      if (!m0_cs_i) begin
        m0_we_i = we; m0_addr_i = a; m0_wdata_i = d; m0_cs_i = 1'b1;
      end
    end else begin
      if (!m1_cs_i) begin
        m1_we_i = we; m1_addr_i = a; m1_wdata_i = d; m1_cs_i = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; m0_cs_i = 1'b0; m1_cs_i = 1'b0; rvalid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One transaction: expect a grant on the next edge, lat BUSY cycles with no
  // response, then the response cycle; the owner drops cs in the IDLE cycle.
  task automatic txn(input int exp_w, input int lat, input logic [DW-1:0] rd, input string nm);
    int            waited;
    logic [1:0]    oh;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    oh  = (exp_w == 0) ? 2'b01 : 2'b10;
    ewe = (exp_w == 0) ? m0_we_i    : m1_we_i;
    ea  = (exp_w == 0) ? m0_addr_i  : m1_addr_i;
    ed  = (exp_w == 0) ? m0_wdata_i : m1_wdata_i;
    waited = 0;
    do begin
      @(posedge clk_i); #1; waited++;
    end while (!cs_o && waited < 4);
    chk({nm, " cs latency"}, DW'(waited), DW'(1));
    chk({nm, " grant"}, DW'(grant_o), DW'(oh));
    chk({nm, " we_o"}, DW'(we_o), DW'(ewe));
    chk({nm, " addr_o"}, DW'(addr_o), DW'(ea));
    chk({nm, " wdata_o"}, wdata_o, ed);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk_i);
      chk({nm, " early rvalid"}, DW'({m1_rvalid_o, m0_rvalid_o}), DW'(0));
    end
    @(negedge clk_i);
    rvalid_i = 1'b1; rdata_i = rd; #1;
    chk({nm, " rvalid"}, DW'({m1_rvalid_o, m0_rvalid_o}), DW'(oh));
    chk({nm, " err"}, DW'({m1_err_o, m0_err_o}), DW'(0));
    chk({nm, " owner rdata"}, (exp_w == 0) ? m0_rdata_o : m1_rdata_o, rd);
    chk({nm, " other rdata"}, (exp_w == 0) ? m1_rdata_o : m0_rdata_o, '0);
    @(posedge clk_i); #1;
    rvalid_i = 1'b0; rdata_i = '0;
    chk({nm, " idle cs"}, DW'(cs_o), DW'(0));
    chk({nm, " idle grant"}, DW'(grant_o), DW'(0));
    if (exp_w == 0) m0_cs_i = 1'b0;
    else m1_cs_i = 1'b0;
  endtask

  typedef struct {
    logic          c0;
    logic          we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          c1;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    int            lat;
    logic [DW-1:0] rd;
    int            exp_w;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int last_w;
    int exp_w;
    tbl[0] = '{1'b1, 1'b0, 32'h0000_1000, 128'h0, 1'b0, 1'b0, 32'h0, 128'h0,
               2, {4{32'hA5A5_A5A5}}, 0};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 128'h0, 1'b1, 1'b1, 32'h4000_0010, 128'h1234,
               1, 128'h0, 1};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_1100, 128'h0, 1'b1, 1'b1, 32'h0000_2200, 128'hBEEF,
               0, 128'h11, 0};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_1200, 128'hCAFE, 1'b1, 1'b0, 32'h0, 128'h0,
               3, 128'h22, 1};
    tbl[4] = '{1'b1, 1'b0, 32'h0, 128'h0, 1'b1, 1'b0, 32'h0000_2300, 128'h0,
               4, 128'h33, 0};
    // Response on the would-be timeout cycle completes normally.
    tbl[5] = '{1'b0, 1'b0, 32'h0, 128'h0, 1'b1, 1'b0, 32'h0, 128'h0,
               TO - 1, 128'h44, 1};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_1300, 128'h0, 1'b0, 1'b0, 32'h0, 128'h0,
               0, 128'h55, 0};

    // Reset values.
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst cs_o", DW'(cs_o), DW'(0));
    chk("rst we_o", DW'(we_o), DW'(0));
    chk("rst addr_o", DW'(addr_o), DW'(0));
    chk("rst wdata_o", wdata_o, '0);
    chk("rst grant", DW'(grant_o), DW'(0));
    chk("rst rvalid", DW'({m1_rvalid_o, m0_rvalid_o, m1_err_o, m0_err_o}), DW'(0));
    chk("rst rdata", m0_rdata_o | m1_rdata_o, '0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].c0) request(0, tbl[i].we0, tbl[i].a0, tbl[i].d0);
      if (tbl[i].c1) request(1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      txn(tbl[i].exp_w, tbl[i].lat, tbl[i].rd, $sformatf("vec%0d", i));
    end

    // rvalid_i while idle is not forwarded.
    @(negedge clk_i);
    rvalid_i = 1'b1; rdata_i = 128'h99; #1;
    chk("idle rvalid", DW'({m1_rvalid_o, m0_rvalid_o}), DW'(0));
    @(posedge clk_i); #1;
    rvalid_i = 1'b0; rdata_i = '0;
    chk("idle stays", DW'({cs_o, grant_o}), DW'(0));

    // Requester input changes while busy do not reach the bus.
    request(0, 1'b0, 32'h0000_2000, 128'h0);
    @(posedge clk_i); #1;
    chk("hold grant", DW'(grant_o), DW'(2'b01));
    @(negedge clk_i);
    m0_addr_i = 32'h0000_3000; m0_we_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("hold addr", DW'(addr_o), DW'(32'h0000_2000));
      chk("hold we", DW'(we_o), DW'(0));
    end
    @(negedge clk_i);
    rvalid_i = 1'b1; rdata_i = 128'h77; #1;
    chk("hold rvalid", DW'({m1_rvalid_o, m0_rvalid_o}), DW'(2'b01));
    chk("hold rdata", m0_rdata_o, 128'h77);
    @(posedge clk_i); #1;
    rvalid_i = 1'b0; rdata_i = '0; m0_cs_i = 1'b0;
    chk("hold idle", DW'(cs_o), DW'(0));

    // Timeout on BUSY cycle TO, then drain the late response.
    request(0, 1'b0, 32'h0000_5000, 128'h0);
    @(posedge clk_i); #1;
    chk("to grant", DW'(grant_o), DW'(2'b01));
    for (int i = 1; i < TO; i++) begin
      @(negedge clk_i);
      chk("to early rvalid", DW'({m1_rvalid_o, m0_rvalid_o}), DW'(0));
    end
    @(negedge clk_i); #1;
    chk("to rvalid", DW'({m1_rvalid_o, m0_rvalid_o}), DW'(2'b01));
    chk("to err", DW'({m1_err_o, m0_err_o}), DW'(2'b01));
    chk("to rdata", m0_rdata_o, 128'hDEAD_BEEF);
    @(posedge clk_i); #1;
    m0_cs_i = 1'b0;
    request(1, 1'b1, 32'h0000_6000, 128'h66);
    repeat (3) begin
      chk("drain cs", DW'(cs_o), DW'(1));
      chk("drain grant", DW'(grant_o), DW'(0));
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    rvalid_i = 1'b1; rdata_i = 128'h88; #1;
    chk("drain discard", DW'({m1_rvalid_o, m0_rvalid_o, m1_err_o, m0_err_o}), DW'(0));
    @(posedge clk_i); #1;
    rvalid_i = 1'b0; rdata_i = '0;
    chk("drain exit", DW'({cs_o, grant_o}), DW'(0));
    txn(1, 1, 128'h61, "after drain");

    // Reset mid-transaction, then the first tie goes to m0.
    request(0, 1'b0, 32'h0000_7000, 128'h0);
    @(posedge clk_i); #1;
    chk("mrst grant", DW'(grant_o), DW'(2'b01));
    @(negedge clk_i);
    rst_i = 1'b1;
    request(1, 1'b0, 32'h0000_8000, 128'h0);
    @(posedge clk_i); #1;
    chk("mrst cs", DW'(cs_o), DW'(0));
    chk("mrst grant0", DW'(grant_o), DW'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    txn(0, 1, 128'h70, "post-rst m0");
    txn(1, 2, 128'h80, "post-rst m1");

    // Randomized traffic against the round-robin model.
    do_reset();
    last_w = 1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1, 0) == 1)
        request(0, 1'($urandom_range(1, 0)), $urandom(),
                {$urandom(), $urandom(), $urandom(), $urandom()});
      if ($urandom_range(1, 0) == 1)
        request(1, 1'($urandom_range(1, 0)), $urandom(),
                {$urandom(), $urandom(), $urandom(), $urandom()});
      if (!m0_cs_i && !m1_cs_i)
        request(int'($urandom_range(1, 0)), 1'b0, $urandom(), '0);
      if (m0_cs_i && m1_cs_i) exp_w = 1 - last_w;
      else exp_w = m0_cs_i ? 0 : 1;
      txn(exp_w, int'($urandom_range(TO - 1, 0)),
          {$urandom(), $urandom(), $urandom(), $urandom()}, $sformatf("rnd%0d", it));
      last_w = exp_w;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
